// File: rtl/osc_cal_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : osc_cal_pkg                                                     |
// | Desc     : State/phase encodings and coarse thermometer mapping for the    |
// |            ring-oscillator frequency calibration controller.               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package osc_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SETTLE      = 3'd1,
        ST_MEASURE     = 3'd2,
        ST_COARSE_EVAL = 3'd3,
        ST_FINE_EVAL   = 3'd4,
        ST_CHECK       = 3'd5,
        ST_DONE        = 3'd6,
        ST_FAIL        = 3'd7
    } cal_state_t;

    typedef enum logic [1:0] {
        PH_COARSE = 2'd0,
        PH_FINE   = 2'd1,
        PH_CHECK  = 2'd2
    } cal_phase_t;

    // Coarse index c lights c bits from bit 0 upward.
    function automatic logic [6:0] coarse_therm(input logic [2:0] idx);
        logic [6:0] w_code;
        w_code = '0;
        for (int i = 0; i < 7; i++) begin
            if (i < int'(idx)) w_code[i] = 1'b1;
        end
        return w_code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/osc_edge_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : osc_edge_counter                                                |
// | Desc     : Windowed saturating counter of synchronized oscillator edges.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module osc_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             clear,
    input  logic             win_active,
    input  logic             osc_edge,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (win_active && osc_edge && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/osc_freq_cal.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : osc_freq_cal                                                    |
// | Desc     : Coarse linear + fine binary search of ring-oscillator delay     |
// |            code against a programmed edge-count target.                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module osc_freq_cal
    import osc_cal_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WIN_CYC    = 1024,
    parameter int SETTLE_CYC = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             cal_start,
    input  logic [CNT_W-1:0] target_cnt,
    input  logic [7:0]       tol,
    input  logic [3:0]       con_perb_cfg,
    input  logic             osc_edge,
    output logic             glob_en,
    output logic [6:0]       delay_con_msb,
    output logic [3:0]       delay_con_lsb,
    output logic [3:0]       con_perb,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             cal_fail,
    output logic [CNT_W-1:0] meas_cnt
);

    localparam int TMR_W = $clog2(((WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC) + 1);

    cal_state_t       r_state;
    cal_phase_t       r_phase;
    logic [2:0]       r_c;
    logic [3:0]       r_f;
    logic [1:0]       r_k;
    logic [TMR_W-1:0] r_cyc;
    logic             r_glob_en;
    logic             r_busy;
    logic             r_done;
    logic             r_fail;
    logic [3:0]       r_con_perb;
    logic [CNT_W-1:0] r_meas;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W:0]   w_diff;
    logic [CNT_W:0]   w_abs;
    logic             w_pass;
    logic [3:0]       w_bit_k;
    logic [3:0]       w_f_kept;

    osc_edge_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rstb       (rstb),
        .clear      (r_state == ST_SETTLE),
        .win_active (r_state == ST_MEASURE),
        .osc_edge   (osc_edge),
        .count      (w_count)
    );

    // The counter holds its value through the eval cycle, so eval decisions
    // use it directly while meas_cnt is loaded in the same cycle.
    assign w_diff   = {1'b0, w_count} - {1'b0, target_cnt};
    assign w_abs    = w_diff[CNT_W] ? (~w_diff + (CNT_W+1)'(1)) : w_diff;
    assign w_pass   = (w_abs <= (CNT_W+1)'(tol));
    assign w_bit_k  = 4'b0001 << r_k;
    assign w_f_kept = (w_count < target_cnt) ? (r_f & ~w_bit_k) : r_f;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= ST_IDLE;
            r_phase    <= PH_COARSE;
            r_c        <= '0;
            r_f        <= '0;
            r_k        <= '0;
            r_cyc      <= '0;
            r_glob_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_con_perb <= '0;
            r_meas     <= '0;
        end else begin
            r_con_perb <= con_perb_cfg;
            case (r_state)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (cal_start) begin
                        r_c       <= '0;
                        r_f       <= 4'hF;
                        r_k       <= 2'd3;
                        r_phase   <= PH_COARSE;
                        r_glob_en <= 1'b1;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_fail    <= 1'b0;
                        r_cyc     <= '0;
                        r_state   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cyc == TMR_W'(SETTLE_CYC - 1)) begin
                        r_cyc   <= '0;
                        r_state <= ST_MEASURE;
                    end else begin
                        r_cyc <= r_cyc + TMR_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (r_cyc == TMR_W'(WIN_CYC - 1)) begin
                        r_cyc <= '0;
                        case (r_phase)
                            PH_COARSE: r_state <= ST_COARSE_EVAL;
                            PH_FINE:   r_state <= ST_FINE_EVAL;
                            default:   r_state <= ST_CHECK;
                        endcase
                    end else begin
                        r_cyc <= r_cyc + TMR_W'(1);
                    end
                end
                ST_COARSE_EVAL: begin
                    r_meas  <= w_count;
                    r_state <= ST_SETTLE;
                    if ((w_count > target_cnt) && (r_c != 3'd7)) begin
                        r_c <= r_c + 3'd1;
                    end else begin
                        r_f     <= 4'b1000;
                        r_k     <= 2'd3;
                        r_phase <= PH_FINE;
                    end
                end
                ST_FINE_EVAL: begin
                    r_meas  <= w_count;
                    r_state <= ST_SETTLE;
                    if (r_k != 2'd0) begin
                        r_f <= w_f_kept | (w_bit_k >> 1);
                        r_k <= r_k - 2'd1;
                    end else begin
                        r_f     <= w_f_kept;
                        r_phase <= PH_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_meas <= w_count;
                    r_busy <= 1'b0;
                    if (w_pass) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_fail  <= 1'b1;
                        r_state <= ST_FAIL;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign glob_en       = r_glob_en;
    assign delay_con_msb = coarse_therm(r_c);
    assign delay_con_lsb = r_f;
    assign con_perb      = r_con_perb;
    assign cal_busy      = r_busy;
    assign cal_done      = r_done;
    assign cal_fail      = r_fail;
    assign meas_cnt      = r_meas;

endmodule
`default_nettype wire

// File: tb/tb_osc_freq_cal.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_osc_freq_cal                                                 |
// | Desc     : Directed scoreboard bench for osc_freq_cal with an oscillator   |
// |            model of 1000 - 100*c - 5*f edges per window.                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_osc_freq_cal;

    localparam int STEP = 16 + 1024 + 1;

    typedef struct {
        int          which;
        logic [6:0]  msb;
        logic [3:0]  lsb;
        logic [15:0] meas;
        logic        done;
        logic        fail;
        int          cycles;
    } exp_t;

    logic        clk;
    logic        rstb;
    logic        cal_start;
    logic [15:0] target_cnt;
    logic [7:0]  tol;
    logic [3:0]  con_perb_cfg;
    logic        osc_edge;
    logic        glob_en;
    logic [6:0]  delay_con_msb;
    logic [3:0]  delay_con_lsb;
    logic [3:0]  con_perb;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_fail;
    logic [15:0] meas_cnt;

    logic        cal_start_8;
    logic [7:0]  target_8;
    logic        osc_edge_8;
    logic        glob_en_8;
    logic [6:0]  msb_8;
    logic [3:0]  lsb_8;
    logic [3:0]  perb_8;
    logic        busy_8;
    logic        done_8;
    logic        fail_8;
    logic [7:0]  meas_8;

    int   tests;
    int   fails;
    int   ph;
    int   cyc;
    exp_t sb_q[$];

    osc_freq_cal #(.CNT_W(16), .WIN_CYC(1024), .SETTLE_CYC(16)) u_dut (
        .clk           (clk),
        .rstb          (rstb),
        .cal_start     (cal_start),
        .target_cnt    (target_cnt),
        .tol           (tol),
        .con_perb_cfg  (con_perb_cfg),
        .osc_edge      (osc_edge),
        .glob_en       (glob_en),
        .delay_con_msb (delay_con_msb),
        .delay_con_lsb (delay_con_lsb),
        .con_perb      (con_perb),
        .cal_busy      (cal_busy),
        .cal_done      (cal_done),
        .cal_fail      (cal_fail),
        .meas_cnt      (meas_cnt)
    );

    osc_freq_cal #(.CNT_W(8), .WIN_CYC(1024), .SETTLE_CYC(16)) u_dut8 (
        .clk           (clk),
        .rstb          (rstb),
        .cal_start     (cal_start_8),
        .target_cnt    (target_8),
        .tol           (tol),
        .con_perb_cfg  (con_perb_cfg),
        .osc_edge      (osc_edge_8),
        .glob_en       (glob_en_8),
        .delay_con_msb (msb_8),
        .delay_con_lsb (lsb_8),
        .con_perb      (perb_8),
        .cal_busy      (busy_8),
        .cal_done      (done_8),
        .cal_fail      (fail_8),
        .meas_cnt      (meas_8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int model_n(input logic [6:0] msb, input logic [3:0] lsb);
        return 1000 - 100 * $countones(msb) - 5 * int'(lsb);
    endfunction

    // Period-1024 edge pattern: any 1024-cycle window with a fixed code sees exactly N edges.
    initial begin
        osc_edge   = 1'b0;
        osc_edge_8 = 1'b0;
        ph         = 0;
        forever begin
            @(posedge clk);
            #1;
            ph         = (ph == 1023) ? 0 : ph + 1;
            osc_edge   = (ph < model_n(delay_con_msb, delay_con_lsb));
            osc_edge_8 = (ph < model_n(msb_8, lsb_8));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int which, input int start, output int total);
        total = start;
        while (((which == 0) ? cal_busy : busy_8) && (total < 20000)) begin
            tick();
            total++;
        end
    endtask

    task automatic cmp_result(input string tag, input int which, input int cycles);
        exp_t e;
        chk({tag, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        if (which == 0) begin
            chk({tag, ".msb"},  32'(delay_con_msb), 32'(e.msb));
            chk({tag, ".lsb"},  32'(delay_con_lsb), 32'(e.lsb));
            chk({tag, ".meas"}, 32'(meas_cnt),      32'(e.meas));
            chk({tag, ".done"}, 32'(cal_done),      32'(e.done));
            chk({tag, ".fail"}, 32'(cal_fail),      32'(e.fail));
            chk({tag, ".glob"}, 32'(glob_en),       32'd1);
        end else begin
            chk({tag, ".msb"},  32'(msb_8),  32'(e.msb));
            chk({tag, ".lsb"},  32'(lsb_8),  32'(e.lsb));
            chk({tag, ".meas"}, 32'(meas_8), 32'(e.meas));
            chk({tag, ".done"}, 32'(done_8), 32'(e.done));
            chk({tag, ".fail"}, 32'(fail_8), 32'(e.fail));
        end
        chk({tag, ".cycles"}, 32'(cycles), 32'(e.cycles));
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rstb         = 1'b0;
        cal_start    = 1'b0;
        cal_start_8  = 1'b0;
        target_cnt   = 16'd640;
        target_8     = 8'd200;
        tol          = 8'd4;
        con_perb_cfg = 4'h0;

        // Reset values
        repeat (3) tick();
        chk("rst.glob_en",  32'(glob_en),       32'd0);
        chk("rst.msb",      32'(delay_con_msb), 32'd0);
        chk("rst.lsb",      32'(delay_con_lsb), 32'd0);
        chk("rst.con_perb", 32'(con_perb),      32'd0);
        chk("rst.status",   32'({cal_busy, cal_done, cal_fail}), 32'd0);
        chk("rst.meas",     32'(meas_cnt),      32'd0);

        // Idle without start
        rstb = 1'b1;
        repeat (2000) tick();
        chk("idle.glob_en", 32'(glob_en), 32'd0);
        chk("idle.status",  32'({cal_busy, cal_done, cal_fail}), 32'd0);
        chk("idle.msb",     32'(delay_con_msb), 32'd0);
        con_perb_cfg = 4'h3;
        tick();
        chk("idle.perb", 32'(con_perb), 32'h3);

        // Nominal search with an ignored mid-MEASURE start and a perturbation change
        sb_q.push_back('{0, 7'h07, 4'hC, 16'd640, 1'b1, 1'b0, 9 * STEP});
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        chk("start.glob_en", 32'(glob_en), 32'd1);
        chk("start.busy",    32'(cal_busy), 32'd1);
        chk("start.code",    32'({delay_con_msb, delay_con_lsb}), 32'({7'h00, 4'hF}));
        repeat (500) tick();
        chk("meas1.code", 32'({delay_con_msb, delay_con_lsb}), 32'({7'h00, 4'hF}));
        cal_start    = 1'b1;
        con_perb_cfg = 4'hA;
        chk("perb.before", 32'(con_perb), 32'h3);
        tick();
        cal_start = 1'b0;
        chk("perb.after", 32'(con_perb), 32'hA);
        wait_idle(0, 501, cyc);
        cmp_result("nominal", 0, cyc);

        // Abort by reset in the fine phase
        target_cnt = 16'd100;
        cal_start  = 1'b1;
        tick();
        cal_start = 1'b0;
        repeat (8 * STEP + 500) tick();
        chk("fine.code", 32'({delay_con_msb, delay_con_lsb}), 32'({7'h7F, 4'h8}));
        #3;
        rstb = 1'b0;
        #1;
        chk("abort.glob_en", 32'(glob_en), 32'd0);
        chk("abort.code",    32'({delay_con_msb, delay_con_lsb}), 32'd0);
        chk("abort.status",  32'({cal_busy, cal_done, cal_fail}), 32'd0);
        chk("abort.meas",    32'(meas_cnt), 32'd0);
        chk("abort.perb",    32'(con_perb), 32'd0);
        tick();
        rstb = 1'b1;
        tick();

        // Restart into the fail case
        sb_q.push_back('{0, 7'h7F, 4'hF, 16'd225, 1'b0, 1'b1, 13 * STEP});
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        chk("restart.code", 32'({delay_con_msb, delay_con_lsb}), 32'({7'h00, 4'hF}));
        chk("restart.busy", 32'(cal_busy), 32'd1);
        wait_idle(0, 0, cyc);
        cmp_result("fail", 0, cyc);

        // 8-bit counter saturation
        sb_q.push_back('{1, 7'h7F, 4'hF, 16'd225, 1'b0, 1'b1, 13 * STEP});
        cal_start_8 = 1'b1;
        tick();
        cal_start_8 = 1'b0;
        repeat (STEP) tick();
        chk("sat.meas", 32'(meas_8), 32'd255);
        chk("sat.msb",  32'(msb_8),  32'h01);
        wait_idle(1, STEP, cyc);
        cmp_result("sat", 1, cyc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/osc_freq_cal.md
# osc_freq_cal

Digital frequency-calibration controller for the five-stage ring oscillator core. It drives the core's enable and delay-control word, counts oscillator edges against the reference clock, and runs a coarse linear search plus a fine binary search to bring the oscillator count to a programmed target. It sits in the reference-clock domain beside the oscillator and receives a pre-divided, synchronized single-cycle edge pulse from the upstream divider/synchronizer.

## Interface
- CNT_W, 16: edge-counter and target width.
- WIN_CYC, 1024: measurement window length in clk cycles.
- SETTLE_CYC, 16: idle clk cycles after every code change before counting.
- clk  input  1  reference clock; all logic on rising edge.
- rstb  input  1  asynchronous active-low reset.
- cal_start  input  1  one-cycle start request.
- target_cnt  input  CNT_W  desired edge count per window.
- tol  input  8  allowed absolute count error for pass.
- con_perb_cfg  input  4  perturbation setting passed to the core.
- osc_edge  input  1  one-cycle pulse per divided oscillator edge (already synchronous to clk).
- glob_en  output  1  oscillator enable.
- delay_con_msb  output  7  coarse delay, thermometer code of coarse index c (0..7).
- delay_con_lsb  output  4  fine delay, binary index f (0..15).
- con_perb  output  4  registered copy of con_perb_cfg.
- cal_busy, cal_done, cal_fail  output  1 each  status.
- meas_cnt  output  CNT_W  last completed measurement.

## Operation
- Higher c or f means more delay and a lower count. delay_con_msb has c ones from bit 0 upward, for example c=3 gives 7'b0000111.
- States: IDLE, SETTLE, MEASURE, COARSE_EVAL, FINE_EVAL, CHECK, DONE, FAIL.
- IDLE/DONE/FAIL + cal_start: c=0, f=15, phase=COARSE, glob_en=1, cal_busy=1, cal_done and cal_fail cleared, go to SETTLE. cal_start is ignored in every other state.
- SETTLE: wait SETTLE_CYC cycles, then go to MEASURE with the counter cleared.
- MEASURE: for exactly WIN_CYC cycles, count osc_edge pulses, saturating at all-ones. Then load meas_cnt and go to the eval state for the current phase.
- COARSE_EVAL: if meas_cnt > target_cnt and c<7, then c++ and go to SETTLE. Otherwise set f=4'b1000, bit index k=3, phase=FINE, and go to SETTLE.
- FINE_EVAL: if meas_cnt < target_cnt, clear f[k]. If k>0: k--, set f[k], go to SETTLE. If k==0: phase=CHECK, go to SETTLE; this final measurement uses the final f.
- CHECK: if |meas_cnt − target_cnt| <= tol, go to DONE, else FAIL. The difference is computed at CNT_W+1 bits signed.
- DONE/FAIL: the code is held, glob_en stays 1, cal_busy=0, and exactly one of cal_done or cal_fail is 1.
- con_perb follows con_perb_cfg with one-cycle latency in all states.

## Timing
- Reset values: glob_en=0, delay_con_msb=0, delay_con_lsb=0, con_perb=0, cal_busy=0, cal_done=0, cal_fail=0, meas_cnt=0, state=IDLE.
- cal_start sampled high at edge N: glob_en, cal_busy and the code outputs take their new values after edge N.
- Each measurement step takes SETTLE_CYC + WIN_CYC + 1 (eval) cycles. The code outputs change only on eval-state exits.
- An osc_edge in the first and the last window cycle is counted. Edges during SETTLE or eval are dropped.
- Coarse saturation: c=7 with the count still above target moves on to the fine phase and does not fail immediately.
- Counter saturation: meas_cnt is clamped to 2^CNT_W−1. It never wraps.
- rstb low at any point, including mid-window: all outputs return to reset values asynchronously and the machine goes to IDLE.

## Structure
- Package osc_cal_pkg: state enum, phase enum, and a function mapping a 3-bit coarse index to the 7-bit thermometer code.
- Sub-module osc_edge_counter: windowed saturating counter with inputs clear, window-active and osc_edge, and output count.
- The FSM and search registers live in osc_freq_cal.

## Test plan
Bench osc model: edges per window = 1000 − 100·c − 5·f. Use WIN_CYC=1024 and SETTLE_CYC=16.
- Reset: hold rstb low, then check that all outputs are 0. Release, and with no cal_start for 2000 cycles the state stays IDLE with glob_en=0.
- Nominal: target=640, tol=4, pulse cal_start. Require c=3 (msb=7'b0000111), lsb=4'b1100, meas_cnt=640, cal_done=1, total 9 steps = 9·1041 cycles.
- Fail: target=100, tol=4. Require c=7 (msb=7'h7F), f=15, meas_cnt=225, cal_fail=1, cal_done=0.
- Saturation: CNT_W=8 with the model at c=0 giving 1000 edges. Require meas_cnt=255 and no wrap. The coarse search still advances.
- Restart/abort: cal_start pulsed mid-MEASURE is ignored. rstb pulsed mid-FINE gives immediate reset values. A later cal_start restarts the search from c=0, f=15.
- Pass-through: change con_perb_cfg to 4'hA during calibration. con_perb must read 4'hA one cycle later, and the search result is unaffected.
